demux_checker: RTL and testbench
================================

DEMUX_CHECKER -- requirements
Module: demux_checker

Interface
REQ-001 Parameter WIDTH, default 8: width of each compared data bus.
REQ-002 Parameter CNT_W, default 8: width of each mismatch counter.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_L, input, 1 bit: asynchronous reset, active-high (asserted when 1 despite the suffix).
REQ-005 The block SHALL have port data_out0_c, input, WIDTH: channel-0 output of the behavioural demux.
REQ-006 The block SHALL have port data_out1_c, input, WIDTH: channel-1 output of the behavioural demux.
REQ-007 The block SHALL have port data_out0_e, input, WIDTH: channel-0 output of the synthesized structural demux.
REQ-008 The block SHALL have port data_out1_e, input, WIDTH: channel-1 output of the synthesized structural demux.
REQ-009 The block SHALL have port check_out0, output, 1 bit: 1 = channel-0 buses matched on the previous sampled edge.
REQ-010 The block SHALL have port check_out1, output, 1 bit: 1 = channel-1 buses matched on the previous sampled edge.
REQ-011 The block SHALL have port err_sticky, output, 1 bit: 1 = any mismatch seen since the last reset.
REQ-012 The block SHALL have port mism_cnt0, output, CNT_W: count of channel-0 mismatch cycles.
REQ-013 The block SHALL have port mism_cnt1, output, CNT_W: count of channel-1 mismatch cycles.
REQ-014 The block SHALL have port first_bad, output, 2 bits: channels mismatching on the first error edge, bit0 = ch0, bit1 = ch1.

Function
REQ-015 Each rising clk edge with reset deasserted, check_out0 SHALL register (data_out0_c == data_out0_e), compared bitwise over all WIDTH bits.
REQ-016 check_out1 SHALL likewise register (data_out1_c == data_out1_e).
REQ-017 Latency SHALL be exactly one clock from input sample to check_out update.
REQ-018 Any bit that is X or Z on either bus SHALL count as a mismatch, not a match.
REQ-019 On every edge where a channel mismatches, err_sticky SHALL set to 1 and remain 1 until reset.
REQ-020 On the first edge after reset with any mismatch, first_bad SHALL capture {mismatch1, mismatch0}; it SHALL then be frozen until reset.
REQ-021 Each mismatch counter SHALL increment by 1 per mismatching edge of its own channel.
REQ-022 Each counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-023 Channels SHALL be independent; simultaneous mismatches SHALL update both counters on the same edge.
REQ-024 The block SHALL have no handshake: inputs are sampled every cycle and no valid qualification is applied.

Reset
REQ-025 While reset_L = 1, asynchronously: check_out0 = check_out1 = 0, err_sticky = 0, first_bad = 2'b00, and both counters = 0.
REQ-026 Reset asserted mid-run SHALL clear all state immediately, without waiting for a clock edge.
REQ-027 The first compare SHALL occur on the first rising edge with reset_L = 0.

Configuration
REQ-028 The macro DEMUX_CHECKER_COUNT_EN SHALL control the mismatch counters.
REQ-029 With DEMUX_CHECKER_COUNT_EN defined, mism_cnt0 and mism_cnt1 SHALL behave per REQ-021 to REQ-023.
REQ-030 With DEMUX_CHECKER_COUNT_EN undefined, no counter registers SHALL be built and mism_cnt0 and mism_cnt1 SHALL be constant 0; all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset then equal buses: reset_L = 1, then 0; drive ch0 = ch1 = 8'hFF on both c and e -> check_out0 = check_out1 = 1 one edge later, err_sticky = 0, counters = 0.
REQ-032 Single ch0 error: data_out0_c = 8'hEE, data_out0_e = 8'hEF for one cycle -> check_out0 = 0 for one cycle then back to 1; mism_cnt0 = 1; err_sticky = 1; first_bad = 2'b01.
REQ-033 Simultaneous error: ch0 8'hAA vs 8'hAB and ch1 8'h99 vs 8'h98 on the same edge -> both checks 0, both counters +1, first_bad = 2'b11 if this is the first error after reset.
REQ-034 Saturation: hold a ch1 mismatch for 300 cycles with CNT_W = 8 -> mism_cnt1 = 255 and stays 255.
REQ-035 Mid-run reset: assert reset_L between clock edges after errors -> all outputs 0 immediately; after release, matching inputs give check_out = 1 and err_sticky = 0.
REQ-036 X input: data_out1_e = 8'hxx while data_out1_c = 8'h07 -> check_out1 = 0 and mism_cnt1 increments.

Source files
------------

// File: rtl/demux_checker.sv
// Cycle-by-cycle equivalence checker for behavioural vs. structural demux outputs.
// Optional mismatch counters are built only when DEMUX_CHECKER_COUNT_EN is defined.
module demux_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_out0_c,
    input  logic [WIDTH-1:0] data_out1_c,
    input  logic [WIDTH-1:0] data_out0_e,
    input  logic [WIDTH-1:0] data_out1_e,
    output logic             check_out0,
    output logic             check_out1,
    output logic             err_sticky,
    output logic [CNT_W-1:0] mism_cnt0,
    output logic [CNT_W-1:0] mism_cnt1,
    output logic [1:0]       first_bad
);

    logic       mism0_s;
    logic       mism1_s;
    logic       check0_q;
    logic       check0_d;
    logic       check1_q;
    logic       check1_d;
    logic       err_q;
    logic       err_d;
    logic [1:0] first_bad_q;
    logic [1:0] first_bad_d;

    // Channel compare: an unknown equality result falls to the else arm, so X/Z reads as a mismatch.
    always_comb begin
        mism0_s = 1'b1;
        mism1_s = 1'b1;
        if (data_out0_c == data_out0_e) begin
            mism0_s = 1'b0;
        end else begin
            mism0_s = 1'b1;
        end
        if (data_out1_c == data_out1_e) begin
            mism1_s = 1'b0;
        end else begin
            mism1_s = 1'b1;
        end
    end

    // Next-state for match flags, sticky error and first-error capture.
    always_comb begin
        check0_d    = ~mism0_s;
        check1_d    = ~mism1_s;
        err_d       = err_q;
        first_bad_d = first_bad_q;
        if (mism0_s || mism1_s) begin
            err_d = 1'b1;
            if (!err_q) begin
                first_bad_d = {mism1_s, mism0_s};
            end else begin
                first_bad_d = first_bad_q;
            end
        end else begin
            err_d       = err_q;
            first_bad_d = first_bad_q;
        end
    end

    // Status register bank.
    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            check0_q    <= 1'b0;
            check1_q    <= 1'b0;
            err_q       <= 1'b0;
            first_bad_q <= 2'b00;
        end else begin
            check0_q    <= check0_d;
            check1_q    <= check1_d;
            err_q       <= err_d;
            first_bad_q <= first_bad_d;
        end
    end

    assign check_out0 = check0_q;
    assign check_out1 = check1_q;
    assign err_sticky = err_q;
    assign first_bad  = first_bad_q;

`ifdef DEMUX_CHECKER_COUNT_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt0_d;
    logic [CNT_W-1:0] cnt1_q;
    logic [CNT_W-1:0] cnt1_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Counter next-state: one step per mismatching edge of the channel, held at all-ones.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (mism0_s) begin
            cnt0_d = sat_inc(cnt0_q);
        end else begin
            cnt0_d = cnt0_q;
        end
        if (mism1_s) begin
            cnt1_d = sat_inc(cnt1_q);
        end else begin
            cnt1_d = cnt1_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            cnt0_q <= {CNT_W{1'b0}};
            cnt1_q <= {CNT_W{1'b0}};
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign mism_cnt0 = cnt0_q;
    assign mism_cnt1 = cnt1_q;
`else
    assign mism_cnt0 = {CNT_W{1'b0}};
    assign mism_cnt1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_demux_checker.sv
// Directed scoreboard bench for demux_checker; expected outputs come from a small reference model.
module tb_demux_checker;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [7:0] c0, c1, e0, e1;
    logic       check_out0, check_out1, err_sticky;
    logic [7:0] mism_cnt0, mism_cnt1;
    logic [1:0] first_bad;

    typedef struct {
        logic       ck0;
        logic       ck1;
        logic       err;
        logic [1:0] fb;
        logic [7:0] n0;
        logic [7:0] n1;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   total  = 0;
    int   passed = 0;

    demux_checker #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .data_out0_c(c0),
        .data_out1_c(c1),
        .data_out0_e(e0),
        .data_out1_e(e1),
        .check_out0 (check_out0),
        .check_out1 (check_out1),
        .err_sticky (err_sticky),
        .mism_cnt0  (mism_cnt0),
        .mism_cnt1  (mism_cnt1),
        .first_bad  (first_bad)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m.ck0 = 1'b0; m.ck1 = 1'b0; m.err = 1'b0; m.fb = 2'b00;
        m.n0 = 8'd0;  m.n1 = 8'd0;
    endtask

    task automatic compare_all(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            chk({tag, "_ck0"}, {31'd0, check_out0}, {31'd0, x.ck0});
            chk({tag, "_ck1"}, {31'd0, check_out1}, {31'd0, x.ck1});
            chk({tag, "_err"}, {31'd0, err_sticky}, {31'd0, x.err});
            chk({tag, "_fb"},  {30'd0, first_bad},  {30'd0, x.fb});
            chk({tag, "_n0"},  {24'd0, mism_cnt0},  {24'd0, x.n0});
            chk({tag, "_n1"},  {24'd0, mism_cnt1},  {24'd0, x.n1});
        end
    endtask

    // Drive one cycle of stimulus, predict the result, then check it one edge later.
    task automatic step(input string tag, input logic [7:0] a0, input logic [7:0] b0,
                        input logic [7:0] a1, input logic [7:0] b1);
        logic mm0, mm1;
        c0 = a0; e0 = b0; c1 = a1; e1 = b1;
        mm0 = !(a0 === b0);
        mm1 = !(a1 === b1);
        m.ck0 = !mm0;
        m.ck1 = !mm1;
        if (mm0 || mm1) begin
            if (!m.err) m.fb = {mm1, mm0};
            m.err = 1'b1;
        end
`ifdef DEMUX_CHECKER_COUNT_EN
        if (mm0 && m.n0 != 8'hFF) m.n0 = m.n0 + 8'd1;
        if (mm1 && m.n1 != 8'hFF) m.n1 = m.n1 + 8'd1;
`endif
        sb.push_back(m);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        c0 = 8'h00; c1 = 8'h00; e0 = 8'h00; e1 = 8'h00;
        reset_L = 1'b1;
        model_reset();
        #12;
        sb.push_back(m);
        compare_all("reset");
        @(posedge clk);
        #1;
        reset_L = 1'b0;

        step("eq_ff", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        step("eq_a5", 8'hA5, 8'hA5, 8'h3C, 8'h3C);
        step("ch0_err", 8'hEE, 8'hEF, 8'h3C, 8'h3C);
        step("ch0_back", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        step("both_err_late", 8'hAA, 8'hAB, 8'h99, 8'h98);
        step("ch1_x", 8'h10, 8'h10, 8'h07, 8'hxx);
        step("eq_after_x", 8'h01, 8'h01, 8'h80, 8'h80);

        // Reset between edges must clear everything without a clock.
        #2;
        reset_L = 1'b1;
        #1;
        model_reset();
        sb.push_back(m);
        compare_all("midrst_async");
        @(posedge clk);
        #1;
        sb.push_back(m);
        compare_all("midrst_held");
        reset_L = 1'b0;

        step("post_rst_eq", 8'h55, 8'h55, 8'h66, 8'h66);
        step("both_err_first", 8'hAA, 8'hAB, 8'h99, 8'h98);
        step("ch1_only", 8'h00, 8'h00, 8'h01, 8'h03);

        for (int i = 0; i < 300; i++) begin
            step("sat_ch1", 8'h12, 8'h12, 8'h40, 8'h41);
        end
        step("sat_hold", 8'h12, 8'h12, 8'h40, 8'h41);
        step("sat_eq", 8'h12, 8'h12, 8'h40, 8'h40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
